// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with start/stop/done handshake and optional
// auto-reload for periodic ticks.
module countdown_timer #(
  parameter int unsigned N = 16,
  parameter int unsigned P = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [N-1:0] load_value,
  input  logic [P-1:0] prescale,
  input  logic         auto_reload,
  input  logic         start,
  input  logic         stop,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] reload_q, reload_d;
  logic [P-1:0] presc_q, presc_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         step;

  // >= rather than == so a live shrink of prescale steps next cycle instead of wrapping
  assign step = (state_q == StRun) && (presc_q >= prescale);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    presc_d  = presc_q;
    done_d   = 1'b0;

    if (load) begin
      count_d  = load_value;
      reload_d = load_value;
      presc_d  = '0;
      if ((state_q == StRun) && (load_value == '0)) begin
        state_d = StIdle;
      end
    end else if (stop) begin
      if (state_q == StRun) begin
        state_d = StIdle;
      end
    end else if (start && (state_q == StIdle) && (count_q != '0)) begin
      state_d = StRun;
      presc_d = '0;
    end else if (state_q == StRun) begin
      if (step) begin
        presc_d = '0;
        if (count_q > N'(1)) begin
          count_d = count_q - N'(1);
        end else begin
          // Terminal step: count never shows 0 while auto-reloading
          done_d = 1'b1;
          if (auto_reload && (reload_q != '0)) begin
            count_d = reload_q;
          end else begin
            count_d = '0;
            state_d = StIdle;
          end
        end
      end else begin
        presc_d = presc_q + P'(1);
      end
    end

    busy_d = (state_d == StRun);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      presc_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      presc_q  <= presc_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign count = count_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: per-cycle expected outputs are queued
// with the stimulus and compared against captured DUT outputs per scenario.
module tb_countdown_timer;

  logic        clk;
  logic        reset_n;
  logic        load;
  logic [15:0] load_value;
  logic [7:0]  prescale;
  logic        auto_reload;
  logic        start;
  logic        stop;
  logic [15:0] count;
  logic        busy;
  logic        done;

  typedef struct packed {
    logic [15:0] cnt;
    logic        busy;
    logic        done;
  } obs_t;

  obs_t exp_q[$];
  obs_t obs_q[$];
  int   checks   = 0;
  int   failures = 0;

  countdown_timer #(.N(16), .P(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .prescale   (prescale),
    .auto_reload(auto_reload),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  // Drive one cycle of strobes, queue the outputs expected after the edge, capture actual.
  task automatic cyc(input logic ld, input logic [15:0] lv, input logic st, input logic sp,
                     input logic [15:0] ec, input logic eb, input logic ed);
    load       = ld;
    load_value = lv;
    start      = st;
    stop       = sp;
    exp_q.push_back({ec, eb, ed});
    @(posedge clk);
    #1;
    obs_q.push_back({count, busy, done});
    load  = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; load = 0; load_value = 0; prescale = 0;
    auto_reload = 0; start = 0; stop = 0;
    #3;
    checks++;
    if ({count, busy, done} !== 18'h0) begin
      failures++;
      $display("FAIL reset_state: got cnt=%0d busy=%b done=%b, exp 0 0 0", count, busy, done);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_idle: got cnt=%0d busy=%b done=%b, exp cnt=%0d busy=%b done=%b",
                 o.cnt, o.busy, o.done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_basic;
    prescale = 0; auto_reload = 0;
    cyc(1, 5, 0, 0, 5, 0, 0);
    cyc(0, 0, 1, 0, 5, 1, 0);
    for (int i = 4; i >= 1; i--) cyc(0, 0, 0, 0, 16'(i), 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL basic: got cnt=%0d busy=%b done=%b, exp cnt=%0d busy=%b done=%b",
                 o.cnt, o.busy, o.done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_prescale;
    prescale = 3; auto_reload = 0;
    cyc(1, 2, 0, 0, 2, 0, 0);
    cyc(0, 0, 1, 0, 2, 1, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 2, 1, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL prescale: got cnt=%0d busy=%b done=%b, exp cnt=%0d busy=%b done=%b",
                 o.cnt, o.busy, o.done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_auto_reload;
    prescale = 0; auto_reload = 1;
    cyc(1, 3, 0, 0, 3, 0, 0);
    cyc(0, 0, 1, 0, 3, 1, 0);
    for (int r = 0; r < 2; r++) begin
      cyc(0, 0, 0, 0, 2, 1, 0);
      cyc(0, 0, 0, 0, 1, 1, 0);
      cyc(0, 0, 0, 0, 3, 1, 1);
    end
    cyc(0, 0, 0, 0, 2, 1, 0);
    auto_reload = 0;
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL auto_reload: got cnt=%0d busy=%b done=%b, exp cnt=%0d busy=%b done=%b",
                 o.cnt, o.busy, o.done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_stop_resume;
    prescale = 1; auto_reload = 0;
    cyc(1, 10, 0, 0, 10, 0, 0);
    cyc(0, 0, 1, 0, 10, 1, 0);
    cyc(0, 0, 0, 0, 10, 1, 0);
    cyc(0, 0, 0, 0, 9, 1, 0);
    cyc(0, 0, 0, 0, 9, 1, 0);
    cyc(0, 0, 0, 0, 8, 1, 0);
    cyc(0, 0, 0, 0, 8, 1, 0);
    cyc(0, 0, 0, 0, 7, 1, 0);
    cyc(0, 0, 0, 0, 7, 1, 0);
    // This edge would be a step; stop must win
    cyc(0, 0, 0, 1, 7, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 7, 0, 0);
    cyc(0, 0, 1, 0, 7, 1, 0);
    cyc(0, 0, 0, 0, 7, 1, 0);
    cyc(0, 0, 0, 0, 6, 1, 0);
    prescale = 0;
    cyc(1, 2, 0, 0, 2, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 1, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL stop_resume: got cnt=%0d busy=%b done=%b, exp cnt=%0d busy=%b done=%b",
                 o.cnt, o.busy, o.done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_edge_cmds;
    prescale = 0; auto_reload = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 8, 0, 0, 8, 0, 0);
    cyc(0, 0, 1, 0, 8, 1, 0);
    cyc(0, 0, 0, 0, 7, 1, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(1, 5, 0, 0, 5, 0, 0);
    cyc(0, 0, 1, 0, 5, 1, 0);
    cyc(0, 0, 0, 0, 4, 1, 0);
    cyc(1, 9, 0, 0, 9, 1, 0);
    cyc(0, 0, 1, 0, 8, 1, 0);
    cyc(1, 2, 0, 0, 2, 1, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    // Load lands on the terminal step: no done, keeps running
    cyc(1, 6, 0, 0, 6, 1, 0);
    cyc(0, 0, 0, 0, 5, 1, 0);
    cyc(0, 0, 0, 1, 5, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL edge_cmds: got cnt=%0d busy=%b done=%b, exp cnt=%0d busy=%b done=%b",
                 o.cnt, o.busy, o.done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  task automatic test_reset_midrun;
    prescale = 0; auto_reload = 0;
    cyc(1, 7, 0, 0, 7, 0, 0);
    cyc(0, 0, 1, 0, 7, 1, 0);
    cyc(0, 0, 0, 0, 6, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({count, busy, done} !== 18'h0) begin
      failures++;
      $display("FAIL reset_midrun: got cnt=%0d busy=%b done=%b, exp 0 0 0", count, busy, done);
    end
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      obs_t e = exp_q.pop_front();
      obs_t o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL reset_midrun_seq: got cnt=%0d busy=%b done=%b, exp cnt=%0d busy=%b done=%b",
                 o.cnt, o.busy, o.done, e.cnt, e.busy, e.done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_auto_reload();
    test_stop_resume();
    test_edge_cmds();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable, prescaled down-counter with a start/stop/done handshake. It counts down from a programmed value and reports expiry, complementing the free-running up-counters in the cube FPGA. Control logic uses it for frame, refresh and delay intervals: it loads a value, starts the timer and waits for `done`. An optional auto-reload mode turns it into a periodic tick source.

## Interface
Parameters:
- `N`, 16: width of the count and load value.
- `P`, 8: width of the prescaler.

Ports:
- `clk`  in  1  clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `load`  in  1  one-cycle strobe; loads `load_value` into the count and into the reload register.
- `load_value`  in  N  value captured on `load`.
- `prescale`  in  P  one count step every `prescale`+1 clk cycles; sampled live.
- `auto_reload`  in  1  on expiry, reload from the reload register and keep running; sampled live.
- `start`  in  1  one-cycle strobe; begin or resume counting.
- `stop`  in  1  one-cycle strobe; pause counting and hold the count.
- `count`  out  N  current count, registered.
- `busy`  out  1  high while in RUN, registered.
- `done`  out  1  one-cycle expiry pulse, registered.

## Operation
- Internal state:
  - `count` register (N bits).
  - `reload` register (N bits).
  - `presc` register (P bits).
  - FSM with two states, IDLE and RUN.
- Reset values: `count`=0, `reload`=0, `presc`=0, state IDLE, `busy`=0, `done`=0.
- Step condition: state RUN and `presc` >= `prescale`. On a step, `presc`<=0. Otherwise in RUN, `presc`<=`presc`+1.
  - The >= comparison means a live decrease of `prescale` below `presc` causes a step on the next cycle, with no wrap.
- Command priority per cycle is load > stop > start > step.
- `load`, in any state:
  - `count`<=`load_value`, `reload`<=`load_value`, `presc`<=0.
  - State is unchanged, except RUN goes to IDLE if `load_value`==0.
  - No `done` pulse.
- `stop` in RUN: go to IDLE; `count` holds, `presc` holds. `stop` in IDLE has no effect.
- `start` in IDLE with `count`!=0: go to RUN with `presc`<=0.
- `start` ignored cases:
  - In IDLE with `count`==0: no state change and no `done`.
  - In RUN.
- Step with `count`>1: `count`<=`count`-1.
- Step with `count`==1 (terminal step): `done`<=1 for exactly one cycle, then:
  - If `auto_reload`=1 and `reload`!=0: `count`<=`reload` and remain in RUN. `count` never displays 0 in this mode.
  - Otherwise: `count`<=0 and go to IDLE.
- `done` is 0 in every cycle that is not a terminal step.
- `busy` is the registered value of (next state == RUN).
- Arithmetic: the decrement is modulo 2^N, but `count` never goes below 0 because the terminal step intercepts 1 -> 0.

## Timing
- Start to busy: `start` sampled at edge E0 sets `busy`=1 after E0.
- First decrement occurs at edge E0+`prescale`+1.
- Full countdown from L with prescale p:
  - Terminal step at edge E0+L*(p+1).
  - `done`=1 and `busy`=0 (non-reload mode) during the following cycle.
- Auto-reload: `done` pulses every L*(p+1) cycles, with `busy` held high throughout.
- `load` effects: `load` at edge E updates `count` after E. A `load` while RUN restarts the prescale window.
- Stop/resume: after `stop`, `count` holds. A later `start` resumes with a fresh prescale window of p+1 cycles before the next step.
- Collisions:
  - `stop` coincident with a step or terminal step: stop wins, with no decrement and no `done`.
  - `load` coincident with a terminal step: load wins, with no `done`.
- Reset mid-run: asserting `reset_n`=0 asynchronously forces all registers to their reset values. Counting resumes only on a new `load` and `start` after deassertion.

## Test plan
- Basic countdown:
  - Stimulus: `load_value`=5, p=0, `load`, then `start`.
  - Response: `count` 5,4,3,2,1,0 on consecutive cycles; `done`=1 for one cycle with `count`=0; `busy` falls in the same cycle.
- Prescaled countdown:
  - Stimulus: L=2, p=3, `start` at E0.
  - Response: decrements at E0+4 and E0+8; single `done` after E0+8; `count` constant between steps.
- Auto-reload:
  - Stimulus: L=3, p=0, `auto_reload`=1.
  - Response: `count` 3,2,1,3,2,1...; `done` every 3 cycles coincident with `count`=3; `busy` stays 1. Clearing `auto_reload` ends the run at 0 with `busy`=0.
- Stop/resume and collisions:
  - Stimulus: L=10, p=1; `stop` when `count`=7; wait 5 cycles; `start`.
  - Response: `count` holds at 7; after restart, next decrement occurs 2 cycles later.
  - Stimulus: `stop` coincident with the terminal step.
  - Response: `count`=1, no `done`.
- Edge commands:
  - Stimulus: `start` with `count`=0.
  - Response: no `busy`, no `done`.
  - Stimulus: `load` of 0 while RUN.
  - Response: IDLE, `count`=0, no `done`.
  - Stimulus: `load` of 9 while RUN with `count`=4.
  - Response: `count`=9, still RUN.
- Reset mid-run:
  - Stimulus: assert `reset_n`=0 mid-count.
  - Response: `count`=0, `busy`=0, `done`=0 immediately, independent of `clk`; `start` alone afterward is ignored.
